// File: rtl/kpn_seq_multiplier.sv
// Sequential shift-and-add multiplier node: pops one operand pair, emits a 2*WIDTH-bit product.
// Latency: product pushed WIDTH+1 cycles after the LOAD edge; one product per WIDTH+3 cycles at best.
// Backpressure: holds in WRITE with wr low and output_1 stable while the output FIFO reports full.
module kpn_seq_multiplier #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               empty_1,
  input  logic               empty_2,
  input  logic [WIDTH-1:0]   entry_1,
  input  logic [WIDTH-1:0]   entry_2,
  input  logic               full,
  output logic               rd,
  output logic               wr,
  output logic [2*WIDTH-1:0] output_1,
  output logic               busy
);

  localparam int            PW   = 2 * WIDTH;
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    WRITE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand_ext;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   acc_next;
  logic [CW-1:0]   count;
  logic            last;

  // Partial product for the current multiplier bit; in signed mode the top bit carries negative weight
  always_comb begin
    mcand_ext = {{WIDTH{SIGNED & mcand[WIDTH-1]}}, mcand};
    last      = (count == LAST);
    partial   = mplier[count] ? (mcand_ext << count) : '0;
    if (SIGNED && last) begin
      acc_next = acc - partial;
    end else begin
      acc_next = acc + partial;
    end
  end

  // Push strobe is combinational so a full flag drop is honoured in the same cycle
  always_comb begin
    wr   = (state == WRITE) && !full;
    busy = (state != IDLE);
  end

  // Control FSM with registered pop strobe, operand capture and product register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd       <= 1'b0;
      output_1 <= '0;
      acc      <= '0;
      count    <= '0;
      mcand    <= '0;
      mplier   <= '0;
    end else begin
      rd <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty_1 && !empty_2) begin
            state <= LOAD;
            rd    <= 1'b1;
          end
        end
        LOAD: begin
          mcand  <= entry_1;
          mplier <= entry_2;
          acc    <= '0;
          count  <= '0;
          state  <= CALC;
        end
        CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (last) begin
            output_1 <= acc_next;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (!full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kpn_seq_multiplier.sv
// Bench for kpn_seq_multiplier: unsigned and signed instances fed from queue-modelled show-ahead FIFOs.
// Expected products are queued at stimulus time and compared when wr is seen.
// Output FIFO fullness is driven directly by the stimulus.
module tb_kpn_seq_multiplier;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // unsigned instance signals
  logic          e1_u = 1'b1, e2_u = 1'b1, full_u = 1'b0;
  logic [W-1:0]  d1_u = '0, d2_u = '0;
  logic          rd_u, wr_u, busy_u;
  logic [2*W-1:0] out_u;
  // signed instance signals
  logic          e1_s = 1'b1, e2_s = 1'b1, full_s = 1'b0;
  logic [W-1:0]  d1_s = '0, d2_s = '0;
  logic          rd_s, wr_s, busy_s;
  logic [2*W-1:0] out_s;

  kpn_seq_multiplier #(.WIDTH(W), .SIGNED(1'b0)) u_uns (
    .clk(clk), .reset(reset), .empty_1(e1_u), .empty_2(e2_u),
    .entry_1(d1_u), .entry_2(d2_u), .full(full_u),
    .rd(rd_u), .wr(wr_u), .output_1(out_u), .busy(busy_u)
  );

  kpn_seq_multiplier #(.WIDTH(W), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .reset(reset), .empty_1(e1_s), .empty_2(e2_s),
    .entry_1(d1_s), .entry_2(d2_s), .full(full_s),
    .rd(rd_s), .wr(wr_s), .output_1(out_s), .busy(busy_s)
  );

  logic [W-1:0]   qa_u[$], qb_u[$], qa_s[$], qb_s[$];
  logic [2*W-1:0] exp_u[$], exp_s[$];
  int             wr_cyc_u[$];

  int n_chk = 0;
  int n_pass = 0;
  int rd_cnt_u = 0, wr_cnt_u = 0, wr_cnt_s = 0;
  int load_cyc_u = 0;
  logic rd_prev_u = 1'b0;
  logic lat_en = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_u(input logic [W-1:0] a, input logic [W-1:0] b);
    qa_u.push_back(a);
    qb_u.push_back(b);
    exp_u.push_back({16'h0, a} * {16'h0, b});
  endtask

  task automatic push_s(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    qa_s.push_back(a);
    qb_s.push_back(b);
    exp_s.push_back(32'(sa * sb));
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_u.size() > 0 || exp_s.size() > 0 || busy_u || busy_s) && n < 500);
    if (n >= 500) chk("drain_timeout", n, 0);
    @(negedge clk);
  endtask

  // show-ahead FIFO models: pop on rd, present head word and empty flag
  always @(posedge clk) begin
    if (rd_u && qa_u.size() > 0 && qb_u.size() > 0) begin
      qa_u.delete(0);
      qb_u.delete(0);
    end
    if (rd_s && qa_s.size() > 0 && qb_s.size() > 0) begin
      qa_s.delete(0);
      qb_s.delete(0);
    end
  end

  always @(negedge clk) begin
    e1_u = (qa_u.size() == 0);
    e2_u = (qb_u.size() == 0);
    d1_u = e1_u ? '0 : qa_u[0];
    d2_u = e2_u ? '0 : qb_u[0];
    e1_s = (qa_s.size() == 0);
    e2_s = (qb_s.size() == 0);
    d1_s = e1_s ? '0 : qa_s[0];
    d2_s = e2_s ? '0 : qb_s[0];
  end

  // unsigned-instance monitor: pulse shape, latency, scoreboard
  always @(negedge clk) begin
    if (rd_u) begin
      chk("rd_single_pulse_u", rd_prev_u, 1'b0);
      rd_cnt_u++;
      load_cyc_u = cyc;
    end
    if (rd_u || wr_u) chk("rd_wr_exclusive_u", rd_u & wr_u, 1'b0);
    if (wr_u) begin
      wr_cnt_u++;
      wr_cyc_u.push_back(cyc);
      if (lat_en) chk("latency_u", cyc - load_cyc_u, 17);
      if (exp_u.size() == 0) chk("spurious_wr_u", exp_u.size(), 1);
      else chk("product_u", out_u, exp_u.pop_front());
    end
    rd_prev_u = rd_u;
  end

  // signed-instance monitor: scoreboard only
  always @(negedge clk) begin
    if (wr_s) begin
      wr_cnt_s++;
      if (exp_s.size() == 0) chk("spurious_wr_s", exp_s.size(), 1);
      else chk("product_s", out_s, exp_s.pop_front());
    end
  end

  initial begin
    int snap_rd, snap_wr, waited;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_u", rd_u, 0);
    chk("rst_wr_u", wr_u, 0);
    chk("rst_busy_u", busy_u, 0);
    chk("rst_out_u", out_u, 0);
    chk("rst_busy_s", busy_s, 0);
    chk("rst_out_s", out_s, 0);
    reset = 1'b0;

    // T1: 3*5 with one rd and one wr
    snap_rd = rd_cnt_u;
    snap_wr = wr_cnt_u;
    push_u(16'd3, 16'd5);
    drain();
    chk("t1_rd_count", rd_cnt_u - snap_rd, 1);
    chk("t1_wr_count", wr_cnt_u - snap_wr, 1);
    chk("t1_out", out_u, 32'h0000000F);

    // T2: max operands and zero operand
    push_u(16'hFFFF, 16'hFFFF);
    push_u(16'h0000, 16'h1234);
    drain();
    chk("t2_out_zero", out_u, 32'h0);

    // T3: signed products
    push_s(16'hFFFD, 16'd5);
    push_s(16'h8000, 16'h8000);
    push_s(16'h7FFF, 16'h8000);
    drain();
    chk("t3_out_last", out_s, 32'hC0008000);

    // T4: backpressure held in WRITE
    lat_en = 1'b0;
    full_u = 1'b1;
    snap_wr = wr_cnt_u;
    push_u(16'd7, 16'd9);
    repeat (25) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_wr_held", wr_u, 0);
      chk("t4_busy", busy_u, 1);
      chk("t4_out_stable", out_u, 32'd63);
    end
    full_u = 1'b0;
    drain();
    chk("t4_one_wr", wr_cnt_u - snap_wr, 1);
    lat_en = 1'b1;

    // T5: one FIFO non-empty -> no pop; then four queued pairs back to back
    snap_rd = rd_cnt_u;
    qa_u.push_back(16'h0011);
    repeat (20) @(negedge clk);
    chk("t5_no_rd", rd_cnt_u - snap_rd, 0);
    wr_cyc_u.delete();
    qb_u.push_back(16'h0022);
    exp_u.push_back({16'h0, 16'h0011} * {16'h0, 16'h0022});
    push_u(16'h1234, 16'h5678);
    push_u(16'hFFFF, 16'h0002);
    push_u(16'h8000, 16'h8000);
    drain();
    chk("t5_wr_count", wr_cyc_u.size(), 4);
    for (int i = 1; i < wr_cyc_u.size(); i++) chk("t5_wr_spacing", wr_cyc_u[i] - wr_cyc_u[i-1], 19);

    // T6: reset while count=7 in CALC
    push_u(16'd100, 16'd200);
    waited = 0;
    while (!rd_u && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rd_u) chk("t6_rd_timeout", waited, 0);
    repeat (8) @(negedge clk);
    snap_wr = wr_cnt_u;
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_rd", rd_u, 0);
    chk("t6_rst_wr", wr_u, 0);
    chk("t6_rst_busy", busy_u, 0);
    chk("t6_rst_out", out_u, 0);
    if (exp_u.size() > 0) exp_u.delete(0);
    @(negedge clk);
    reset = 1'b0;
    push_u(16'd11, 16'd13);
    drain();
    chk("t6_wr_after_abort", wr_cnt_u - snap_wr, 1);
    chk("t6_next_out", out_u, 32'd143);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
